// File: rtl/stage_layer_scheduler_pkg.sv
// Shared types for the layer scheduler: token width and scheduler FSM encoding.
package stage_layer_scheduler_pkg;

  localparam int att_width = 16;

  typedef enum logic [2:0] {
    SCH_IDLE,
    SCH_LOAD,
    SCH_RUN,
    SCH_CAPTURE,
    SCH_DONE
  } stage_sch_state_t;

endpackage

// File: rtl/stage_bias_regfile.sv
// Per-layer bias table: two entries per layer, written from the config port, read
// combinationally by the current layer index.
module stage_bias_regfile
  import stage_layer_scheduler_pkg::*;
#(
  parameter  int N_LAYER = 4,
  localparam int LW      = (N_LAYER > 1) ? $clog2(N_LAYER) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [LW-1:0]        wr_idx,
  input  logic                 wr_sel,
  input  logic [att_width-1:0] wdata,
  input  logic [LW-1:0]        rd_idx,
  output logic [att_width-1:0] bias_1,
  output logic [att_width-1:0] bias_2
);

  logic [att_width-1:0] bias_1_q [N_LAYER];
  logic [att_width-1:0] bias_2_q [N_LAYER];

  // Out-of-range addresses (non power-of-two N_LAYER) are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bias_1_q <= '{default: '0};
      bias_2_q <= '{default: '0};
    end else if (we && (int'(wr_idx) < N_LAYER)) begin
      if (wr_sel) bias_2_q[wr_idx] <= wdata;
      else        bias_1_q[wr_idx] <= wdata;
    end
  end

  assign bias_1 = bias_1_q[rd_idx];
  assign bias_2 = bias_2_q[rd_idx];

endmodule

// File: rtl/stage_layer_scheduler.sv
// Runs one shared stage block N_LAYER times on a token, feeding each layer's result
// back as the next layer's input, with a per-layer RUN timeout.
module stage_layer_scheduler
  import stage_layer_scheduler_pkg::*;
#(
  parameter  int N_LAYER = 4,
  parameter  int TIMEOUT = 255,
  localparam int LW      = (N_LAYER > 1) ? $clog2(N_LAYER) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [att_width-1:0] i_data,
  input  logic                 cfg_we,
  input  logic [LW-1:0]        cfg_addr,
  input  logic                 cfg_sel,
  input  logic [att_width-1:0] cfg_wdata,
  output logic                 stage_en,
  output logic [att_width-1:0] stage_in,
  output logic [att_width-1:0] stage_bias_1,
  output logic [att_width-1:0] stage_bias_2,
  input  logic                 stage_end,
  input  logic [att_width-1:0] stage_out,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [att_width-1:0] o_data,
  output logic [LW-1:0]        layer_idx
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  stage_sch_state_t     state_q, state_d;
  logic [att_width-1:0] act_q;
  logic [att_width-1:0] o_data_q;
  logic [LW-1:0]        layer_q;
  logic [CW-1:0]        cnt_q;
  logic                 err_q;
  logic                 timeout_hit;
  logic                 last_layer;

  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));
  assign last_layer  = (layer_q == LW'(N_LAYER - 1));

  // Table writes are only honoured while idle so biases stay stable during a pass.
  stage_bias_regfile #(.N_LAYER(N_LAYER)) u_bias_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (cfg_we && (state_q == SCH_IDLE)),
    .wr_idx (cfg_addr),
    .wr_sel (cfg_sel),
    .wdata  (cfg_wdata),
    .rd_idx (layer_q),
    .bias_1 (stage_bias_1),
    .bias_2 (stage_bias_2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= SCH_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    stage_en = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state_q)
      SCH_IDLE: begin
        busy = 1'b0;
        if (start) state_d = SCH_LOAD;
      end
      SCH_LOAD: state_d = SCH_RUN;
      SCH_RUN: begin
        stage_en = 1'b1;
        // A stage finishing on the last allowed cycle still counts as success.
        if (stage_end)        state_d = SCH_CAPTURE;
        else if (timeout_hit) state_d = SCH_IDLE;
      end
      SCH_CAPTURE: state_d = last_layer ? SCH_DONE : SCH_LOAD;
      SCH_DONE: begin
        done    = 1'b1;
        state_d = SCH_IDLE;
      end
      default: state_d = SCH_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q    <= '0;
      o_data_q <= '0;
      layer_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        SCH_IDLE: begin
          if (start) begin
            act_q   <= i_data;
            layer_q <= '0;
            err_q   <= 1'b0;
          end
        end
        SCH_LOAD: cnt_q <= '0;
        SCH_RUN: begin
          cnt_q <= cnt_q + CW'(1);
          if (!stage_end && timeout_hit) err_q <= 1'b1;
        end
        SCH_CAPTURE: begin
          act_q <= stage_out;
          // Final result lands in o_data so it is valid in the same cycle as done.
          if (last_layer) o_data_q <= stage_out;
          else            layer_q  <= layer_q + LW'(1);
        end
        default: ;
      endcase
    end
  end

  assign stage_in  = act_q;
  assign o_data    = o_data_q;
  assign err       = err_q;
  assign layer_idx = layer_q;

endmodule
